lc3_mem_access_ctrl: RTL and testbench



---
 rtl/lc3_mem_access_ctrl_if.sv | 30 +++
 rtl/lc3_mem_access_ctrl.sv | 100 ++++++++++
 tb/tb_lc3_mem_access_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_access_ctrl_if.sv
// rtl/lc3_mem_access_ctrl_if.sv - request and memory-bus signals of the LC-3 memory access controller
interface lc3_mem_access_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              Start;
  logic              RW;
  logic [DATA_W-1:0] Addr;
  logic [DATA_W-1:0] WData;
  logic              Mem_Req;
  logic              Mem_WE;
  logic [DATA_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_WData;
  logic              Mem_Ack;
  logic [DATA_W-1:0] Mem_RData;
  logic [DATA_W-1:0] MDR_D;
  logic              MDR_WE;
  logic              R;
  logic              Busy;
  logic              Err;

  modport master (
    output Start, RW, Addr, WData, Mem_Ack, Mem_RData,
    input  Mem_Req, Mem_WE, Mem_Addr, Mem_WData, MDR_D, MDR_WE, R, Busy, Err
  );

  modport slave (
    input  Start, RW, Addr, WData, Mem_Ack, Mem_RData,
    output Mem_Req, Mem_WE, Mem_Addr, Mem_WData, MDR_D, MDR_WE, R, Busy, Err
  );
endinterface

// File: rtl/lc3_mem_access_ctrl.sv
// rtl/lc3_mem_access_ctrl.sv - one LC-3 memory transaction per Start; MEM_TIMEOUT_EN adds a REQ-phase timeout abort
module lc3_mem_access_ctrl #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input logic                  Clk,
  input logic                  Reset,
  lc3_mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nxt;
  logic              rw_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mdr_q;
  logic              tmo;
  logic              err_q;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request fields are captured only when a Start is accepted, so Start during Busy cannot disturb them.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdr_q   <= '0;
    end else begin
      if (state == IDLE && bus.Start) begin
        rw_q    <= bus.RW;
        addr_q  <= bus.Addr;
        wdata_q <= bus.WData;
      end
      if (state == REQ && bus.Mem_Ack && !rw_q) mdr_q <= bus.Mem_RData;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // An ack in the final counted cycle takes priority over the abort.
  assign tmo = (state == REQ) && !bus.Mem_Ack && (cnt == TMO_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == REQ) cnt <= cnt + 1'b1;
      else              cnt <= '0;
      if (state == IDLE && bus.Start) err_q <= 1'b0;
      else if (tmo)                   err_q <= 1'b1;
    end
  end
`else
  assign tmo   = 1'b0;
  assign err_q = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    bus.Mem_Req = 1'b0;
    bus.Mem_WE  = 1'b0;
    bus.R       = 1'b0;
    bus.MDR_WE  = 1'b0;
    bus.Busy    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) state_nxt = REQ;
      end
      REQ: begin
        bus.Mem_Req = 1'b1;
        bus.Mem_WE  = rw_q;
        bus.Busy    = 1'b1;
        if (bus.Mem_Ack || tmo) state_nxt = DONE;
      end
      DONE: begin
        bus.R      = 1'b1;
        bus.MDR_WE = !rw_q && !err_q;
        bus.Busy   = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.Mem_Addr  = addr_q;
  assign bus.Mem_WData = wdata_q;
  assign bus.MDR_D     = mdr_q;
  assign bus.Err       = err_q;

endmodule

// File: tb/tb_lc3_mem_access_ctrl.sv
// tb/tb_lc3_mem_access_ctrl.sv - self-checking bench for lc3_mem_access_ctrl
module tb_lc3_mem_access_ctrl;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  lc3_mem_access_ctrl_if #(.DATA_W(DW)) bus ();

  lc3_mem_access_ctrl #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          delay;
    logic        noise;
    logic [15:0] exp_mdr;
  } vec_t;

  vec_t        tbl[7];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mdr_m;
  logic        err_m;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic samp();
    @(negedge Clk);
  endtask

  task automatic chk_cycle(input string tag, input logic req, input logic we, input logic busy,
                           input logic r, input logic mwe);
    chk1({tag, ".Mem_Req"}, bus.Mem_Req, req);
    chk1({tag, ".Mem_WE"},  bus.Mem_WE,  we);
    chk1({tag, ".Busy"},    bus.Busy,    busy);
    chk1({tag, ".R"},       bus.R,       r);
    chk1({tag, ".MDR_WE"},  bus.MDR_WE,  mwe);
    chk1({tag, ".Err"},     bus.Err,     err_m);
    chk16({tag, ".MDR_D"},  bus.MDR_D,   mdr_m);
  endtask

  task automatic run_txn(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdata, input int delay, input logic noise,
                         input logic [15:0] exp_mdr);
    bus.Start     = 1'b1;
    bus.RW        = rw;
    bus.Addr      = addr;
    bus.WData     = wdata;
    bus.Mem_Ack   = noise;
    bus.Mem_RData = 16'($urandom);
    samp();
    chk_cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    err_m = 1'b0;
    for (int k = 0; k <= delay; k++) begin
      bus.Start     = noise;
      bus.RW        = ~rw;
      bus.Addr      = noise ? 16'h5555 : 16'($urandom);
      bus.WData     = 16'($urandom);
      bus.Mem_Ack   = (k == delay);
      bus.Mem_RData = (k == delay) ? rdata : 16'($urandom);
      samp();
      chk_cycle("req", 1'b1, rw, 1'b1, 1'b0, 1'b0);
      chk16("req.Mem_Addr", bus.Mem_Addr, addr);
      chk16("req.Mem_WData", bus.Mem_WData, wdata);
      tick();
    end
    bus.Start   = noise;
    bus.Mem_Ack = noise;
    mdr_m       = exp_mdr;
    samp();
    chk_cycle("done", 1'b0, 1'b0, 1'b1, 1'b1, ~rw);
    tick();
    bus.Start   = 1'b0;
    bus.Mem_Ack = 1'b0;
  endtask

  task automatic idle_cycle(input string tag, input logic ack);
    bus.Start     = 1'b0;
    bus.Mem_Ack   = ack;
    bus.Mem_RData = 16'($urandom);
    samp();
    chk_cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.Mem_Ack = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 16'h3000, 16'h0000, 16'hBEEF, 0, 1'b0, 16'hBEEF};
    tbl[1] = '{1'b1, 16'h4001, 16'h1234, 16'hDEAD, 3, 1'b0, 16'hBEEF};
    tbl[2] = '{1'b0, 16'h3000, 16'h0000, 16'hC0DE, 2, 1'b1, 16'hC0DE};
    tbl[3] = '{1'b0, 16'h0100, 16'h0000, 16'h0001, 0, 1'b0, 16'h0001};
    tbl[4] = '{1'b0, 16'h0101, 16'h0000, 16'h0002, 0, 1'b0, 16'h0002};
    tbl[5] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h7777, 5, 1'b1, 16'h0002};
    tbl[6] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0, 16'h0000};

    Reset         = 1'b1;
    bus.Start     = 1'b1;
    bus.RW        = 1'b1;
    bus.Addr      = 16'hFFFF;
    bus.WData     = 16'hFFFF;
    bus.Mem_Ack   = 1'b1;
    bus.Mem_RData = 16'hFFFF;
    mdr_m         = 16'h0000;
    err_m         = 1'b0;
    tick();
    tick();
    samp();
    chk_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk16("reset.Mem_Addr", bus.Mem_Addr, 16'h0000);
    chk16("reset.Mem_WData", bus.Mem_WData, 16'h0000);
    tick();
    Reset       = 1'b0;
    bus.Start   = 1'b0;
    bus.Mem_Ack = 1'b0;
    idle_cycle("post_reset", 1'b1);

    for (int i = 0; i < 7; i++)
      run_txn(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].delay, tbl[i].noise,
              tbl[i].exp_mdr);
    idle_cycle("tbl_end", 1'b0);

    // Reset in the second REQ cycle, then a late ack.
    bus.Start = 1'b1;
    bus.RW    = 1'b0;
    bus.Addr  = 16'h2222;
    samp();
    chk_cycle("rst.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.Start = 1'b0;
    samp();
    chk_cycle("rst.req1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    Reset = 1'b1;
    samp();
    chk_cycle("rst.req2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    Reset         = 1'b0;
    mdr_m         = 16'h0000;
    bus.Mem_Ack   = 1'b1;
    bus.Mem_RData = 16'hAAAA;
    samp();
    chk_cycle("rst.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_cycle("rst.late_ack", 1'b0);

`ifdef MEM_TIMEOUT_EN
    bus.Start = 1'b1;
    bus.RW    = 1'b0;
    bus.Addr  = 16'h6000;
    samp();
    chk_cycle("tmo.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.Start = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      samp();
      chk_cycle("tmo.req", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    err_m = 1'b1;
    samp();
    chk_cycle("tmo.done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    idle_cycle("tmo.hold", 1'b0);
    run_txn(1'b0, 16'h6001, 16'h0000, 16'h5A5A, TMO - 1, 1'b0, 16'h5A5A);
    idle_cycle("tmo.ackwins", 1'b0);
`endif

    for (int t = 0; t < 40; t++) begin
      logic        rw;
      logic [15:0] rdata;
      int          gaps;
      rw    = 1'($urandom);
      rdata = 16'($urandom);
      gaps  = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) idle_cycle("rnd.gap", 1'($urandom));
      run_txn(rw, 16'($urandom), 16'($urandom), rdata, $urandom_range(0, 5), 1'($urandom),
              rw ? mdr_m : rdata);
    end
    idle_cycle("rnd.end", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
